layer_compositor: RTL and testbench

Parametrised, pipelined successor to the fixed 8-layer priority colour mux in the VGA output path. Sits between the object/sprite generators and the VGA sync output register. Selects the highest-index active layer per pixel and adds:
- per-layer enable and blink masks, applied only on frame boundaries;
- a configurable background colour;
- blanking;
- a per-frame collision flag for game logic.

---
 rtl/layer_compositor.sv | 162 ++++++++++++++++
 tb/tb_layer_compositor.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/layer_compositor.sv
// Pipelined N-layer priority colour compositor for the VGA output path.
// Adds frame-synchronous enable/blink masks, background colour, blanking and collision flag.
module layer_compositor #(
  parameter int                  N_LAYERS     = 8,
  parameter int                  CW           = 1,
  parameter int                  BLINK_FRAMES = 16,
  parameter logic [N_LAYERS-1:0] COLL_MASK    = {N_LAYERS{1'b1}}
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   video_on,
  input  logic                   frame_tick,
  input  logic [N_LAYERS-1:0]    on_objs,
  input  logic [N_LAYERS*CW-1:0] r_objs,
  input  logic [N_LAYERS*CW-1:0] g_objs,
  input  logic [N_LAYERS*CW-1:0] b_objs,
  input  logic                   cfg_we,
  input  logic [N_LAYERS-1:0]    cfg_enable,
  input  logic [N_LAYERS-1:0]    cfg_blink,
  input  logic [3*CW-1:0]        cfg_bg,
  output logic [3*CW-1:0]        rgb,
  output logic [((N_LAYERS > 1) ? $clog2(N_LAYERS) : 1)-1:0] top_layer,
  output logic                   layer_hit,
  output logic                   collision
);

  localparam int TOP_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
  localparam int BC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  function automatic logic [TOP_W-1:0] prio_top(input logic [N_LAYERS-1:0] m);
    logic [TOP_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < N_LAYERS; k++) begin
      if (m[k]) idx = TOP_W'(k);
    end
    return idx;
  endfunction

  // True when at least two bits are set: clearing the lowest set bit leaves something.
  function automatic logic multi_hot(input logic [N_LAYERS-1:0] m);
    return (m & (m - N_LAYERS'(1))) != '0;
  endfunction

  logic [N_LAYERS-1:0] shd_en_q, shd_en_d, shd_blink_q, shd_blink_d;
  logic [3*CW-1:0]     shd_bg_q, shd_bg_d;
  logic [N_LAYERS-1:0] act_en_q, act_en_d, act_blink_q, act_blink_d;
  logic [3*CW-1:0]     act_bg_q, act_bg_d;
  logic [BC_W-1:0]     blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic                coll_acc_q, coll_acc_d, collision_q, collision_d;
  logic                coll_now;
  logic [N_LAYERS-1:0] eff;

  logic [TOP_W-1:0]    top_p1_q, top_p1_d;
  logic                hit_p1_q, hit_p1_d;
  logic [3*CW-1:0]     col_p1_q, col_p1_d;
  logic                vld_p1_q, vld_p1_d;

  logic [3*CW-1:0]     rgb_p2_q, rgb_p2_d;
  logic [TOP_W-1:0]    top_p2_q, top_p2_d;
  logic                hit_p2_q, hit_p2_d;

  // Shadow/active configuration; a write coinciding with the tick passes straight through.
  always_comb begin
    shd_en_d    = cfg_we ? cfg_enable : shd_en_q;
    shd_blink_d = cfg_we ? cfg_blink  : shd_blink_q;
    shd_bg_d    = cfg_we ? cfg_bg     : shd_bg_q;
    act_en_d    = frame_tick ? shd_en_d    : act_en_q;
    act_blink_d = frame_tick ? shd_blink_d : act_blink_q;
    act_bg_d    = frame_tick ? shd_bg_d    : act_bg_q;
  end

  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_tick) begin
      if (blink_cnt_q == BC_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BC_W'(1);
      end
    end
  end

  // Collision ignores blink so a hidden blinking sprite still collides.
  always_comb begin
    coll_now    = video_on & multi_hot(on_objs & act_en_q & COLL_MASK);
    coll_acc_d  = coll_acc_q | coll_now;
    collision_d = collision_q;
    if (frame_tick) begin
      collision_d = coll_acc_q | coll_now;
      coll_acc_d  = 1'b0;
    end
  end

  // ---- stage 1: mask, priority select, colour pre-mux ----
  always_comb begin
    eff      = on_objs & act_en_q & ~(act_blink_q & {N_LAYERS{~blink_phase_q}});
    top_p1_d = prio_top(eff);
    hit_p1_d = |eff;
    col_p1_d = act_bg_q;
    for (int k = 0; k < N_LAYERS; k++) begin
      if (eff[k]) col_p1_d = {b_objs[k*CW +: CW], g_objs[k*CW +: CW], r_objs[k*CW +: CW]};
    end
    vld_p1_d = video_on;
  end

  // ---- stage 2: blanking and output register ----
  always_comb begin
    rgb_p2_d = vld_p1_q ? col_p1_q : '0;
    hit_p2_d = vld_p1_q & hit_p1_q;
    top_p2_d = hit_p2_d ? top_p1_q : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shd_en_q      <= '1;
      shd_blink_q   <= '0;
      shd_bg_q      <= '0;
      act_en_q      <= '1;
      act_blink_q   <= '0;
      act_bg_q      <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      coll_acc_q    <= 1'b0;
      collision_q   <= 1'b0;
      vld_p1_q      <= 1'b0;
      rgb_p2_q      <= '0;
      top_p2_q      <= '0;
      hit_p2_q      <= 1'b0;
    end else begin
      shd_en_q      <= shd_en_d;
      shd_blink_q   <= shd_blink_d;
      shd_bg_q      <= shd_bg_d;
      act_en_q      <= act_en_d;
      act_blink_q   <= act_blink_d;
      act_bg_q      <= act_bg_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      coll_acc_q    <= coll_acc_d;
      collision_q   <= collision_d;
      vld_p1_q      <= vld_p1_d;
      rgb_p2_q      <= rgb_p2_d;
      top_p2_q      <= top_p2_d;
      hit_p2_q      <= hit_p2_d;
    end
  end

  // Stage-1 data is qualified by vld_p1_q, so it needs no reset.
  always_ff @(posedge clk) begin
    top_p1_q <= top_p1_d;
    hit_p1_q <= hit_p1_d;
    col_p1_q <= col_p1_d;
  end

  assign rgb       = rgb_p2_q;
  assign top_layer = top_p2_q;
  assign layer_hit = hit_p2_q;
  assign collision = collision_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Bench for layer_compositor: directed scenarios then random traffic, all checked
// against a frame-level behavioural model.
module tb_layer_compositor;

  localparam int N  = 8;
  localparam int BF = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       video_on = 1'b0, frame_tick = 1'b0, cfg_we = 1'b0;
  logic [7:0] on_objs = '0, r_objs = '0, g_objs = '0, b_objs = '0;
  logic [7:0] cfg_enable = '1, cfg_blink = '0;
  logic [2:0] cfg_bg = '0;
  logic [2:0] rgb;
  logic [2:0] top_layer;
  logic       layer_hit, collision;

  layer_compositor #(.N_LAYERS(N), .CW(1), .BLINK_FRAMES(BF), .COLL_MASK(8'hFF)) dut (
    .clk(clk), .reset(reset), .video_on(video_on), .frame_tick(frame_tick),
    .on_objs(on_objs), .r_objs(r_objs), .g_objs(g_objs), .b_objs(b_objs),
    .cfg_we(cfg_we), .cfg_enable(cfg_enable), .cfg_blink(cfg_blink), .cfg_bg(cfg_bg),
    .rgb(rgb), .top_layer(top_layer), .layer_hit(layer_hit), .collision(collision)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  logic [7:0] m_shd_en = '1, m_shd_bl = '0, m_act_en = '1, m_act_bl = '0;
  logic [2:0] m_shd_bg = '0, m_act_bg = '0;
  int         m_frame = 0;
  logic       m_acc = 1'b0, m_coll = 1'b0;
  logic [6:0] exp_q[$];   // {hit, top, rgb} per pixel in flight

  logic [7:0] c_r = '0, c_g = '0, c_b = '0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step(input logic rs, input logic vo, input logic ft, input logic [7:0] on,
                      input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                      input logic we, input logic [7:0] en, input logic [7:0] bl,
                      input logic [2:0] bg);
    logic [6:0] e;
    logic [7:0] eff;
    logic       vis, coll_now;
    @(negedge clk);
    if (exp_q.size() == 2) begin
      e = exp_q.pop_front();
      check_eq("rgb", {29'd0, rgb}, {29'd0, e[2:0]});
      check_eq("top_layer", {29'd0, top_layer}, {29'd0, e[5:3]});
      check_eq("layer_hit", {31'd0, layer_hit}, {31'd0, e[6]});
    end
    check_eq("collision", {31'd0, collision}, {31'd0, m_coll});
    reset = rs; video_on = vo; frame_tick = ft; on_objs = on;
    r_objs = rr; g_objs = gg; b_objs = bb;
    cfg_we = we; cfg_enable = en; cfg_blink = bl; cfg_bg = bg;
    if (rs) begin
      m_shd_en = '1; m_shd_bl = '0; m_shd_bg = '0;
      m_act_en = '1; m_act_bl = '0; m_act_bg = '0;
      m_frame = 0; m_acc = 1'b0; m_coll = 1'b0;
      exp_q.delete();
      exp_q.push_back(7'd0);
      exp_q.push_back(7'd0);
    end else begin
      vis = ((m_frame / BF) % 2) == 0;
      e = 7'd0;
      if (vo) begin
        eff = on & m_act_en & (vis ? 8'hFF : ~m_act_bl);
        e = {1'b0, 3'd0, m_act_bg};
        for (int k = N - 1; k >= 0; k--) begin
          if (eff[k]) begin
            e = {1'b1, k[2:0], bb[k], gg[k], rr[k]};
            break;
          end
        end
      end
      exp_q.push_back(e);
      coll_now = vo && ($countones(on & m_act_en) >= 2);
      if (ft) begin
        m_coll = m_acc | coll_now;
        m_acc = 1'b0;
        m_frame++;
      end else if (coll_now) begin
        m_acc = 1'b1;
      end
      if (we) begin m_shd_en = en; m_shd_bl = bl; m_shd_bg = bg; end
      if (ft) begin m_act_en = m_shd_en; m_act_bl = m_shd_bl; m_act_bg = m_shd_bg; end
    end
  endtask

  task automatic pix(input logic vo, input logic ft, input logic [7:0] on);
    step(1'b0, vo, ft, on, c_r, c_g, c_b, 1'b0, 8'h00, 8'h00, 3'd0);
  endtask

  initial begin
    step(1'b1, 0, 0, 8'h00, 0, 0, 0, 0, 8'hFF, 0, 0);
    step(1'b1, 0, 0, 8'h00, 0, 0, 0, 0, 8'hFF, 0, 0);
    step(1'b0, 0, 0, 8'h00, 0, 0, 0, 0, 8'hFF, 0, 0);
    check_eq("reset_rgb", {29'd0, rgb}, 32'd0);
    check_eq("reset_hit", {31'd0, layer_hit}, 32'd0);

    // layer 5 wins with r=1,b=1
    c_r = 8'h20; c_g = 8'h04; c_b = 8'h20;
    repeat (3) pix(1, 0, 8'b0010_0100);
    check_eq("tp1_rgb", {29'd0, rgb}, 32'h5);
    check_eq("tp1_top", {29'd0, top_layer}, 32'd5);
    check_eq("tp1_hit", {31'd0, layer_hit}, 32'd1);

    // background, then blanking
    step(0, 0, 1, 8'h00, c_r, c_g, c_b, 1, 8'hFF, 8'h00, 3'b010);
    repeat (3) pix(1, 0, 8'h00);
    check_eq("tp2_bg", {29'd0, rgb}, 32'h2);
    check_eq("tp2_hit", {31'd0, layer_hit}, 32'd0);
    repeat (3) pix(0, 0, 8'h00);
    check_eq("tp2_blank", {29'd0, rgb}, 32'd0);

    // mid-frame enable change waits for the tick
    c_r = 8'h80; c_g = 8'h40; c_b = 8'hC0;
    step(0, 1, 0, 8'hC0, c_r, c_g, c_b, 1, 8'h7F, 8'h00, 3'b010);
    repeat (2) pix(1, 0, 8'hC0);
    check_eq("tp3_pre", {29'd0, top_layer}, 32'd7);
    pix(1, 1, 8'hC0);
    repeat (3) pix(1, 0, 8'hC0);
    check_eq("tp3_post", {29'd0, top_layer}, 32'd6);
    step(0, 1, 1, 8'hC0, c_r, c_g, c_b, 1, 8'hFF, 8'h00, 3'b010);
    repeat (3) pix(1, 0, 8'hC0);
    check_eq("tp3_wt", {29'd0, top_layer}, 32'd7);

    // blink layer 3 with BLINK_FRAMES=2
    step(1, 0, 0, 8'h00, 0, 0, 0, 0, 8'hFF, 0, 0);
    step(0, 0, 0, 8'h00, 0, 0, 0, 1, 8'hFF, 8'h08, 3'b001);
    c_r = 8'h08; c_g = 8'h08; c_b = 8'h00;
    for (int f = 0; f < 6; f++) begin
      repeat (3) pix(1, 0, 8'h08);
      check_eq($sformatf("tp4_f%0d", f), {31'd0, layer_hit}, {31'd0, ((f / 2) % 2) == 0});
      pix(0, 1, 8'h00);
    end

    // collision of layers 1 and 4
    pix(1, 0, 8'h12); pix(1, 0, 8'h00); pix(0, 1, 8'h00); pix(0, 0, 8'h00);
    check_eq("tp5_set", {31'd0, collision}, 32'd1);
    pix(1, 0, 8'h02); pix(0, 1, 8'h00); pix(0, 0, 8'h00);
    check_eq("tp5_clr", {31'd0, collision}, 32'd0);
    pix(0, 0, 8'h12); pix(0, 1, 8'h00); pix(0, 0, 8'h00);
    check_eq("tp5_blank", {31'd0, collision}, 32'd0);

    // reset mid-frame with coll_acc set
    pix(1, 0, 8'h12);
    step(1, 1, 0, 8'h12, c_r, c_g, c_b, 0, 8'hFF, 0, 0);
    step(1, 1, 0, 8'h12, c_r, c_g, c_b, 0, 8'hFF, 0, 0);
    check_eq("tp6_rgb", {29'd0, rgb}, 32'd0);
    check_eq("tp6_hit", {31'd0, layer_hit}, 32'd0);
    pix(0, 1, 8'h00); pix(0, 0, 8'h00);
    check_eq("tp6_coll", {31'd0, collision}, 32'd0);
    c_r = 8'h80; c_g = 8'h00; c_b = 8'h00;
    repeat (3) pix(1, 0, 8'h80);
    check_eq("tp6_en", {29'd0, top_layer}, 32'd7);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 600) == 0, ($urandom % 8) != 0, ($urandom % 40) == 0,
           8'($urandom & $urandom & $urandom), 8'($urandom), 8'($urandom), 8'($urandom),
           ($urandom % 30) == 0, 8'($urandom | $urandom), 8'($urandom & $urandom),
           3'($urandom));
    end
    repeat (3) pix(0, 0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
